// File: rtl/spi_log_serializer.sv
// Serializes {addr,len} flash log events into 4-byte records on a shared byte sink.
// Overflow drops are reported in-band; user bytes pass through when no log traffic is pending.
module spi_log_serializer #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  log_strobe,
   input  logic [23:0]           log_addr,
   input  logic [7:0]            log_len,
   input  logic                  spi_critical,
   input  logic [7:0]            user_txd,
   input  logic                  user_txd_strobe,
   output logic                  user_txd_ready,
   output logic [7:0]            uart_txd,
   output logic                  uart_txd_strobe,
   input  logic                  uart_txd_ready,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic [7:0]            drop_count
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned PW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned IW    = 3;
   localparam int unsigned BYTES = 4;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MARK = 2'd1;
   localparam logic [1:0] S_REC  = 2'd2;

   typedef struct packed {
      logic [23:0] addr;
      logic [7:0]  len;
   } log_rec_t;

   log_rec_t          mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count_nx;
   logic [1:0]        state;
   logic [1:0]        state_nx;
   logic [31:0]       shreg;
   logic [31:0]       shreg_nx;
   logic [IW-1:0]     byte_idx;
   logic [IW-1:0]     byte_idx_nx;
   logic [7:0]        txd_nx;
   logic              stb_nx;
   logic              ovf_flag;
   logic              ovf_nx;
   logic [7:0]        drops_pending;
   logic [7:0]        pend_nx;
   logic [7:0]        drop_nx;

   logic empty;
   logic full;
   logic idle;
   logic load_mark;
   logic pop;
   logic push;
   logic drop;
   logic user_take;

   assign empty = (fifo_count == '0);
   assign full  = (fifo_count == CW'(DEPTH));
   assign idle  = (state == S_IDLE);

   // Arbitration waits for the sink to be ready, so drops collected during a stall are
   // announced before any record queued behind them.
   assign load_mark = idle && uart_txd_ready && ovf_flag;
   assign pop       = idle && uart_txd_ready && !ovf_flag && !empty;
   assign drop      = log_strobe && full && !pop;
   assign push      = log_strobe && !drop;

   assign user_txd_ready = reset_n && uart_txd_ready && !spi_critical && idle && empty
                           && !ovf_flag && !uart_txd_strobe;
   assign user_take      = user_txd_strobe && user_txd_ready;

   // Next-state and registered-output values
   always_comb begin
      state_nx    = state;
      shreg_nx    = shreg;
      byte_idx_nx = byte_idx;
      txd_nx      = uart_txd;
      stb_nx      = 1'b0;
      count_nx    = fifo_count;
      drop_nx     = drop_count;
      ovf_nx      = load_mark ? 1'b0 : ovf_flag;
      pend_nx     = load_mark ? 8'h00 : drops_pending;

      case ({push, pop})
         2'b10:   count_nx = fifo_count + CW'(1);
         2'b01:   count_nx = fifo_count - CW'(1);
         default: count_nx = fifo_count;
      endcase

      if (drop) begin
         ovf_nx = 1'b1;
         if (pend_nx != 8'hFF) pend_nx = pend_nx + 8'd1;
         if (drop_count != 8'hFF) drop_nx = drop_count + 8'd1;
      end

      case (state)
         S_IDLE: begin
            if (load_mark) begin
               shreg_nx    = {24'hFF_FFFF, drops_pending};
               byte_idx_nx = '0;
               state_nx    = S_MARK;
            end else if (pop) begin
               shreg_nx    = mem[rd_ptr];
               byte_idx_nx = '0;
               state_nx    = S_REC;
            end else if (user_take) begin
               txd_nx = user_txd;
               stb_nx = 1'b1;
            end
         end
         S_MARK, S_REC: begin
            if (byte_idx == IW'(BYTES)) begin
               state_nx = S_IDLE;
            end else if (uart_txd_ready && !uart_txd_strobe) begin
               txd_nx      = shreg[31:24];
               stb_nx      = 1'b1;
               shreg_nx    = {shreg[23:0], 8'h00};
               byte_idx_nx = byte_idx + IW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Record storage carries no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {log_addr, log_len};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         shreg           <= '0;
         byte_idx        <= '0;
         uart_txd        <= '0;
         uart_txd_strobe <= 1'b0;
         fifo_count      <= '0;
         drop_count      <= '0;
         drops_pending   <= '0;
         ovf_flag        <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
      end else begin
         state           <= state_nx;
         shreg           <= shreg_nx;
         byte_idx        <= byte_idx_nx;
         uart_txd        <= txd_nx;
         uart_txd_strobe <= stb_nx;
         fifo_count      <= count_nx;
         drop_count      <= drop_nx;
         drops_pending   <= pend_nx;
         ovf_flag        <= ovf_nx;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

endmodule

// File: doc/spi_log_serializer.md
# spi_log_serializer

Sits between the SPI flash emulator's transaction-log outputs and the shared UART/USB-serial byte sink. Each `{addr, len}` log event is buffered in a small FIFO and emitted as an atomic 4-byte record under `uart_txd_ready` flow control. Bytes from the user command parser are passed through when no log traffic is pending. Drops caused by FIFO overflow are counted and reported in-band with a marker record.

## Interface
- `DEPTH_LOG2`, 4, FIFO holds 2^DEPTH_LOG2 records.
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `log_strobe` in 1: single-cycle pulse carrying one log event.
- `log_addr` in 24: flash address of the event.
- `log_len` in 8: byte count of the event.
- `spi_critical` in 1: high blocks user passthrough.
- `user_txd` in 8: user byte.
- `user_txd_strobe` in 1: user byte valid.
- `user_txd_ready` out 1: user byte will be accepted this cycle.
- `uart_txd` out 8: byte to the serial sink.
- `uart_txd_strobe` out 1: single-cycle byte-valid pulse.
- `uart_txd_ready` in 1: sink can take a byte.
- `fifo_count` out DEPTH_LOG2+1: records currently stored.
- `drop_count` out 8: total dropped events, saturating at 255.

## Operation
- **FIFO**
  - 32-bit entries `{log_addr, log_len}`.
  - Push on `log_strobe`.
  - If the FIFO is full and no pop occurs that cycle: the event is dropped, `drop_count` increments (saturating at 255), `drops_pending` increments (saturating at 255), and `ovf_flag` is set.
  - Push and pop in the same cycle while full: the push is accepted and `fifo_count` is unchanged.
- **Serializer states**
  - IDLE → MARK: `ovf_flag` is set. Load `{24'hFFFFFF, drops_pending}`, then clear `ovf_flag` and `drops_pending`. Drops arriving in the same cycle count toward the next marker.
  - IDLE → REC: FIFO not empty. Pop the head into a 32-bit shift register.
  - IDLE → USER: only when neither condition above holds.
  - MARK/REC: send 4 bytes MSB first (`addr[23:16]`, `addr[15:8]`, `addr[7:0]`, `len`), then return to IDLE. A record is never interleaved with other bytes.
  - Priority: marker > FIFO record > user byte.
- **Byte issue rule**
  - A byte is issued at a clock edge only if `uart_txd_ready` is high in that cycle and `uart_txd_strobe` is currently low. The sink's ready may lag by one cycle, so this gives at most one byte every 2 cycles.
  - `uart_txd` is held stable until the next issue.
- **User passthrough**
  - `user_txd_ready` = `reset_n` && `uart_txd_ready` && !`spi_critical` && state==IDLE && FIFO empty && !`ovf_flag` && !`uart_txd_strobe`. This is combinational.
  - When `user_txd_strobe` is high and `user_txd_ready` is high: `uart_txd` <= `user_txd` and the strobe fires on the next edge.
  - A user strobe while ready is low is ignored and the byte is lost.
- **`spi_critical`** does not stall log records. It only blocks the user path.

## Timing
- Reset (`reset_n` low, asynchronous):
  - state = IDLE, FIFO empty.
  - `uart_txd` = 0, `uart_txd_strobe` = 0, `fifo_count` = 0, `drop_count` = 0.
  - `drops_pending` = 0, `ovf_flag` = 0, `user_txd_ready` = 0.
  - A record in flight is abandoned.
- Log latency, with an empty FIFO, IDLE state and ready held high:
  - `log_strobe` at edge N → push at N.
  - Pop and enter REC at N+1.
  - First byte strobe at N+2; bytes 2–4 at N+4, N+6, N+8.
  - Back in IDLE at N+9.
- User latency: 1 cycle from an accepted strobe to `uart_txd_strobe`.
- `fifo_count` updates on the edge following push/pop.
- Ready low mid-record: the serializer holds its state and shift register indefinitely, with no timeout.

## Test plan
- **Single record:** reset, ready=1, `log_strobe` with addr=0x123456, len=0x40 → bytes 12 34 56 40, strobes 2 cycles apart, `fifo_count` returns to 0.
- **Overflow and marker:** DEPTH_LOG2=4, ready=0, 20 strobes with addr=i, len=1 → `fifo_count`=16, `drop_count`=4. Raise ready → FF FF FF 04 is sent first, then records 0..15 in order.
- **Backpressure mid-record:** drop ready after byte 2 for 50 cycles → no strobes during the stall, bytes 3–4 sent correctly once ready returns, no duplicates.
- **User arbitration:** FIFO empty, `user_txd`=0x41 strobed → 0x41 is output 1 cycle later. With `spi_critical`=1, or a record pending, `user_txd_ready`=0 and no user byte appears.
- **Simultaneous push/pop when full:** FIFO full, a pop coincides with `log_strobe` → event accepted, `drop_count` unchanged, `fifo_count` stays 16.
- **Reset mid-record:** assert `reset_n` low after byte 1 → all outputs 0 immediately. After release, a new event emits a clean 4-byte record.
